// File: rtl/elevator_call_scheduler_pkg.sv
// Shared types for the elevator call scheduler: FSM state encoding,
// travel-direction constants and the floor-index width helper.
package elev_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_START,
        ST_WAIT_ACK,
        ST_MOVING,
        ST_SETTLE,
        ST_DOOR,
        ST_FAULT
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic int floor_w(input int num_floors);
        return (num_floors < 2) ? 1 : $clog2(num_floors);
    endfunction

endpackage

// File: rtl/elevator_call_scheduler_call_selector.sv
// Combinational priority finder: nearest pending floor strictly above and
// strictly below the current floor.
module call_selector
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = floor_w(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur_floor,
    output logic                  above_found,
    output logic [FLOOR_W-1:0]    above_floor,
    output logic                  below_found,
    output logic [FLOOR_W-1:0]    below_floor
);

    always_comb begin
        above_found = 1'b0;
        above_floor = '0;
        below_found = 1'b0;
        below_floor = '0;
        // Scan top-down so the last hit above is the lowest one.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(cur_floor))) begin
                above_found = 1'b1;
                above_floor = i[FLOOR_W-1:0];
            end
        end
        // Scan bottom-up so the last hit below is the highest one.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i < int'(cur_floor))) begin
                below_found = 1'b1;
                below_floor = i[FLOOR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN cab scheduler issuing one relative move at a time to main_motor.
// Define ELEV_SCHED_WATCHDOG_EN to enable the start-acknowledge watchdog.
module elevator_call_scheduler
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS    = 8,
    parameter int DOOR_DWELL    = 50_000_000,
    parameter int SETTLE_CYCLES = 1000,
    parameter int START_TIMEOUT = 1000,
    localparam int FLOOR_W      = floor_w(NUM_FLOORS)
) (
    input  logic                    sched_clk,
    input  logic                    sched_reset_n,
    input  logic [NUM_FLOORS-1:0]   call_req,
    input  logic                    moving_check,
    output logic [NUM_FLOORS-1:0]   call_pending,
    output logic signed [31:0]      floor_move_cnt,
    output logic                    move_stop_start,
    output logic [FLOOR_W-1:0]      current_floor,
    output logic                    sched_dir,
    output logic                    door_open,
    output logic                    sched_fault
);

    state_e                  state_q, state_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d, clr_mask;
    logic [31:0]             move_cnt_q, move_cnt_d;
    logic                    start_q, start_d;
    logic [FLOOR_W-1:0]      cur_q, cur_d;
    logic [FLOOR_W-1:0]      target_q, target_d;
    logic [FLOOR_W-1:0]      tgt;
    logic                    dir_q, dir_d;
    logic                    door_q, door_d;
    logic                    fault_q, fault_d;
    logic [31:0]             timer_q, timer_d;

    logic                    above_found, below_found;
    logic [FLOOR_W-1:0]      above_floor, below_floor;

    call_selector #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_call_selector (
        .pending     (pending_q),
        .cur_floor   (cur_q),
        .above_found (above_found),
        .above_floor (above_floor),
        .below_found (below_found),
        .below_floor (below_floor)
    );

    always_comb begin
        state_d    = state_q;
        move_cnt_d = move_cnt_q;
        start_d    = 1'b0;
        cur_d      = cur_q;
        target_d   = target_q;
        dir_d      = dir_q;
        door_d     = door_q;
        fault_d    = fault_q;
        timer_d    = timer_q;
        tgt        = target_q;
        clr_mask   = '0;

        case (state_q)
            ST_IDLE: begin
                if (pending_q[cur_q]) begin
                    state_d = ST_DOOR;
                    door_d  = 1'b1;
                    timer_d = '0;
                end else if (|pending_q) begin
                    state_d = ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                // Keep sweeping in the current direction; reverse only when it is exhausted.
                if (dir_q == DIR_UP) begin
                    if (above_found) begin
                        tgt = above_floor;
                    end else begin
                        tgt   = below_floor;
                        dir_d = DIR_DOWN;
                    end
                end else begin
                    if (below_found) begin
                        tgt = below_floor;
                    end else begin
                        tgt   = above_floor;
                        dir_d = DIR_UP;
                    end
                end
                if (above_found || below_found) begin
                    target_d   = tgt;
                    move_cnt_d = 32'(tgt) - 32'(cur_q);
                    start_d    = 1'b1;
                    state_d    = ST_START;
                end else begin
                    dir_d   = dir_q;
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = ST_WAIT_ACK;
                timer_d = '0;
            end
            ST_WAIT_ACK: begin
                if (moving_check) begin
                    state_d = ST_MOVING;
`ifdef ELEV_SCHED_WATCHDOG_EN
                end else if (timer_q == 32'(START_TIMEOUT - 1)) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else begin
                    timer_d = timer_q + 32'd1;
`endif
                end
            end
            ST_MOVING: begin
                if (!moving_check) begin
                    state_d = ST_SETTLE;
                    timer_d = '0;
                end
            end
            ST_SETTLE: begin
                // Any re-rise is an overshoot correction: arrival needs a clean idle run.
                if (moving_check) begin
                    state_d = ST_MOVING;
                end else if (timer_q == 32'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_DOOR;
                    cur_d   = target_q;
                    door_d  = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            ST_DOOR: begin
                if (call_req[cur_q]) begin
                    timer_d = '0;
                end else if (timer_q == 32'(DOOR_DWELL - 1)) begin
                    state_d = ST_IDLE;
                    door_d  = 1'b0;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The floor whose door is (or is about to be) open never holds a call.
        if (state_d == ST_DOOR) begin
            clr_mask[cur_d] = 1'b1;
        end
        pending_d = (pending_q | call_req) & ~clr_mask;
    end

    always_ff @(posedge sched_clk) begin
        if (!sched_reset_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            move_cnt_q <= '0;
            start_q    <= 1'b0;
            cur_q      <= '0;
            target_q   <= '0;
            dir_q      <= DIR_UP;
            door_q     <= 1'b0;
            fault_q    <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            move_cnt_q <= move_cnt_d;
            start_q    <= start_d;
            cur_q      <= cur_d;
            target_q   <= target_d;
            dir_q      <= dir_d;
            door_q     <= door_d;
            fault_q    <= fault_d;
            timer_q    <= timer_d;
        end
    end

    assign call_pending    = pending_q;
    assign floor_move_cnt  = $signed(move_cnt_q);
    assign move_stop_start = start_q;
    assign current_floor   = cur_q;
    assign sched_dir       = dir_q;
    assign door_open       = door_q;
    assign sched_fault     = fault_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Scoreboard bench for elevator_call_scheduler with a behavioural motor model.
module tb_elevator_call_scheduler;

    localparam int NF = 8;
    localparam int DW = 16;
    localparam int SC = 4;
    localparam int TO = 20;
    localparam int EW = 40;
    localparam logic [3:0] K_START = 4'd1;
    localparam logic [3:0] K_DOOR  = 4'd2;
    localparam int M_OFF = 0, M_NORMAL = 1, M_MANUAL = 2;

`ifdef ELEV_SCHED_WATCHDOG_EN
    localparam logic WD = 1'b1;
`else
    localparam logic WD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NF-1:0]     call_req = '0;
    logic              moving_check;
    logic [NF-1:0]     call_pending;
    logic signed [31:0] floor_move_cnt;
    logic              move_stop_start;
    logic [2:0]        current_floor;
    logic              sched_dir;
    logic              door_open;
    logic              sched_fault;

    int                motor_mode = M_OFF;
    logic              man_val = 1'b0;
    logic              motor_val = 1'b0;
    int                hold_cnt = 0;

    int                checks = 0;
    int                errors = 0;
    logic [EW-1:0]     exp_q[$];

    elevator_call_scheduler #(
        .NUM_FLOORS    (NF),
        .DOOR_DWELL    (DW),
        .SETTLE_CYCLES (SC),
        .START_TIMEOUT (TO)
    ) dut (
        .sched_clk       (clk),
        .sched_reset_n   (rst_n),
        .call_req        (call_req),
        .moving_check    (moving_check),
        .call_pending    (call_pending),
        .floor_move_cnt  (floor_move_cnt),
        .move_stop_start (move_stop_start),
        .current_floor   (current_floor),
        .sched_dir       (sched_dir),
        .door_open       (door_open),
        .sched_fault     (sched_fault)
    );

    // clock / reset
    always #5 clk = ~clk;

    // motor model: busy the cycle after a start pulse, for |cnt|*10 cycles
    assign moving_check = (motor_mode == M_MANUAL) ? man_val : motor_val;

    always @(negedge clk) begin
        if (motor_mode != M_NORMAL) begin
            hold_cnt  = 0;
            motor_val = 1'b0;
        end else if (hold_cnt > 0) begin
            hold_cnt = hold_cnt - 1;
            if (hold_cnt == 0) motor_val = 1'b0;
        end else if (move_stop_start) begin
            motor_val = 1'b1;
            hold_cnt  = ((floor_move_cnt < 0) ? -floor_move_cnt : floor_move_cnt) * 10;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input string name, input logic [EW-1:0] act);
        logic [EW-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event 0x%0h with empty expected queue", name, act);
        end else begin
            e = exp_q.pop_front();
            if (e !== act) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, e);
            end
        end
    endtask

    // scoreboard monitor: start pulses and complete door dwells
    logic       door_prev = 1'b0;
    int         door_len = 0;
    logic [2:0] door_floor = '0;
    logic       door_dir = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (move_stop_start)
                pop_cmp("start_cmd", {K_START, 1'b0, 3'd0, floor_move_cnt});
            if (door_open && !door_prev) begin
                door_floor = current_floor;
                door_dir   = sched_dir;
                door_len   = 0;
                check("pending_cleared_at_door", 32'(call_pending[current_floor]), 32'd0);
            end
            if (door_open) door_len++;
            if (!door_open && door_prev)
                pop_cmp("door_stop", {K_DOOR, door_dir, door_floor, 32'(door_len)});
        end
        door_prev = door_open;
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [NF-1:0] mask);
        call_req = mask;
        @(negedge clk);
        call_req = '0;
    endtask

    task automatic push_start(input logic [31:0] cnt);
        exp_q.push_back({K_START, 1'b0, 3'd0, cnt});
    endtask

    task automatic push_door(input logic dir, input logic [2:0] fl, input int len);
        exp_q.push_back({K_DOOR, dir, fl, 32'(len)});
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || door_open) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s: timeout, %0d events outstanding (expected 0)", name, exp_q.size());
        end
        tick(2);
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!move_stop_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s: no start pulse within 200 cycles (expected one)", name);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pending"}, 32'(call_pending), 32'd0);
        check({tag, "_cnt"},     floor_move_cnt,    32'd0);
        check({tag, "_start"},   32'(move_stop_start), 32'd0);
        check({tag, "_floor"},   32'(current_floor), 32'd0);
        check({tag, "_dir"},     32'(sched_dir),     32'd0);
        check({tag, "_door"},    32'(door_open),     32'd0);
        check({tag, "_fault"},   32'(sched_fault),   32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (expected completion)");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        tick(3);
        check_reset_state("reset");
        rst_n = 1'b1;
        motor_mode = M_NORMAL;
        tick(2);

        // call at floor 5 from reset
        push_start(32'd5);
        push_door(1'b0, 3'd5, DW);
        press(8'h20);
        check("latch_5", 32'(call_pending), 32'h20);
        check("no_start_k", 32'(move_stop_start), 32'd0);
        tick(1);
        check("no_start_k1", 32'(move_stop_start), 32'd0);
        tick(1);
        check("start_at_k2", 32'(move_stop_start), 32'd1);
        check("cnt_plus5", floor_move_cnt, 32'd5);
        wait_drained("serve_5");
        check("floor_5", 32'(current_floor), 32'd5);
        check("pending_after_5", 32'(call_pending), 32'd0);

        // SCAN: 7 first (up), then reverse to 2
        push_start(32'd2);
        push_door(1'b0, 3'd7, DW);
        push_start(32'hFFFF_FFFB);
        push_door(1'b1, 3'd2, DW);
        press(8'h84);
        wait_drained("scan_7_2");
        check("floor_2", 32'(current_floor), 32'd2);
        check("dir_down", 32'(sched_dir), 32'd1);

        // move to 3, then call at current floor with a dwell restart
        push_start(32'd1);
        push_door(1'b0, 3'd3, DW);
        press(8'h08);
        wait_drained("serve_3");
        check("floor_3", 32'(current_floor), 32'd3);
        push_door(1'b0, 3'd3, DW + 5);
        press(8'h08);
        check("door_not_yet", 32'(door_open), 32'd0);
        check("latch_3", 32'(call_pending), 32'h08);
        tick(1);
        check("door_after_1", 32'(door_open), 32'd1);
        tick(4);
        call_req = 8'h08;
        tick(1);
        call_req = '0;
        check("repress_cleared", 32'(call_pending), 32'd0);
        wait_drained("dwell_restart");

        // overshoot: two idle cycles then re-rise must not arrive
        push_start(32'd3);
        push_door(1'b0, 3'd6, DW);
        motor_mode = M_MANUAL;
        man_val = 1'b0;
        press(8'h40);
        wait_start("start_6");
        man_val = 1'b1;
        tick(5);
        man_val = 1'b0;
        tick(2);
        check("no_arrival_overshoot", 32'(door_open), 32'd0);
        man_val = 1'b1;
        tick(3);
        man_val = 1'b0;
        n = 0;
        while (!door_open && n < 50) begin
            tick(1);
            n++;
        end
        check("arrival_latency", 32'(n), 32'(SC + 1));
        motor_mode = M_NORMAL;
        wait_drained("serve_6");
        check("floor_6", 32'(current_floor), 32'd6);

        // motor never acknowledges
        motor_mode = M_OFF;
        push_start(32'hFFFF_FFFB);
        press(8'h02);
        wait_start("start_1");
        tick(TO);
        check("fault_before_timeout", 32'(sched_fault), 32'd0);
        tick(1);
        check("fault_at_timeout", 32'(sched_fault), 32'(WD));
        press(8'h10);
        tick(30);
        check("calls_latch_stalled", 32'(call_pending), 32'h12);
        check("fault_sticky", 32'(sched_fault), 32'(WD));

        // reset during MOVING
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        motor_mode = M_NORMAL;
        tick(2);
        push_start(32'd7);
        press(8'h80);
        wait_start("start_7");
        tick(10);
        rst_n = 1'b0;
        motor_mode = M_OFF;
        tick(1);
        check_reset_state("midmove_reset");
        rst_n = 1'b1;
        tick(5);
        check("idle_after_reset", 32'(move_stop_start), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
